// File: rtl/cam_pkg.sv
// Shared camera definitions: RGB565 field layout, default frame geometry and
// the frame-buffer address width used by the thumbnail decimator.
package cam_pkg;

    localparam int CAM_H_ACTIVE = 640;
    localparam int CAM_V_ACTIVE = 480;
    localparam int CAM_SHIFT    = 3;
    localparam int FB_ADDR_W    = 13;
    localparam int PIX_W        = 16;
    localparam int X_W          = 10;
    localparam int Y_W          = 9;

    localparam int R_W   = 5;
    localparam int G_W   = 6;
    localparam int B_W   = 5;
    localparam int R_LSB = 11;
    localparam int G_LSB = 5;
    localparam int B_LSB = 0;

    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb565_t;

    function automatic rgb565_t rgb565_unpack(input logic [PIX_W-1:0] p);
        rgb565_t c;
        c.r = p[R_LSB +: R_W];
        c.g = p[G_LSB +: G_W];
        c.b = p[B_LSB +: B_W];
        return c;
    endfunction

    function automatic logic [PIX_W-1:0] rgb565_pack(input rgb565_t c);
        logic [PIX_W-1:0] p;
        p = {PIX_W{1'b0}};
        p[R_LSB +: R_W] = c.r;
        p[G_LSB +: G_W] = c.g;
        p[B_LSB +: B_W] = c.b;
        return p;
    endfunction

endpackage

// File: rtl/cam_block_decimator_if.sv
// Camera-side pixel stream and frame-buffer write port of the block decimator.
interface cam_block_decimator_if;

    logic                           pixel_en;
    logic [cam_pkg::PIX_W-1:0]      pixel;
    logic                           href;
    logic                           vsync;
    logic                           wr_en;
    logic [cam_pkg::FB_ADDR_W-1:0]  wr_addr;
    logic [cam_pkg::PIX_W-1:0]      wr_data;
    logic                           frame_done;
    logic                           frame_err;

    modport master (
        output pixel_en, pixel, href, vsync,
        input  wr_en, wr_addr, wr_data, frame_done, frame_err
    );

    modport slave (
        input  pixel_en, pixel, href, vsync,
        output wr_en, wr_addr, wr_data, frame_done, frame_err
    );

endinterface

// File: rtl/block_col_acc.sv
// Per-column vertical accumulators: combinational read-modify-write result,
// committed on the clock edge so each block column updates in a single cycle.
module block_col_acc #(
    parameter int DEPTH = 80,
    parameter int IDX_W = 7,
    parameter int HR_W  = 8,
    parameter int HG_W  = 9,
    parameter int HB_W  = 8,
    parameter int CR_W  = 11,
    parameter int CG_W  = 12,
    parameter int CB_W  = 11
) (
    input  logic             clk,
    input  logic             we,
    input  logic             load,
    input  logic [IDX_W-1:0] idx,
    input  logic [HR_W-1:0]  add_r,
    input  logic [HG_W-1:0]  add_g,
    input  logic [HB_W-1:0]  add_b,
    output logic [CR_W-1:0]  sum_r,
    output logic [CG_W-1:0]  sum_g,
    output logic [CB_W-1:0]  sum_b
);

    logic [CR_W-1:0] mem_r_r [DEPTH];
    logic [CG_W-1:0] mem_g_r [DEPTH];
    logic [CB_W-1:0] mem_b_r [DEPTH];

    // New column value: first block line reloads, later lines add to the stored sum
    always_comb begin
        sum_r = load ? CR_W'(add_r) : mem_r_r[idx] + CR_W'(add_r);
        sum_g = load ? CG_W'(add_g) : mem_g_r[idx] + CG_W'(add_g);
        sum_b = load ? CB_W'(add_b) : mem_b_r[idx] + CB_W'(add_b);
    end

    // Storage needs no reset: every entry is reloaded on the first line of each block row
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r_r[idx] <= sum_r;
            mem_g_r[idx] <= sum_g;
            mem_b_r[idx] <= sum_b;
        end
    end

endmodule

// File: rtl/cam_block_decimator.sv
// Averages each 2^SHIFT square block of the camera frame into one RGB565 pixel
// and writes it to the thumbnail frame buffer at row*OUT_W + col.
module cam_block_decimator
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = CAM_H_ACTIVE,
    parameter int V_ACTIVE = CAM_V_ACTIVE,
    parameter int SHIFT    = CAM_SHIFT
) (
    input  logic                  i_clk,
    input  logic                  reset_n,
    cam_block_decimator_if.slave  bus
);

    localparam int OUT_W = H_ACTIVE >> SHIFT;
    localparam int OUT_H = V_ACTIVE >> SHIFT;
    localparam int IDX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int HR_W  = R_W + SHIFT;
    localparam int HG_W  = G_W + SHIFT;
    localparam int HB_W  = B_W + SHIFT;
    localparam int CR_W  = R_W + 2 * SHIFT;
    localparam int CG_W  = G_W + 2 * SHIFT;
    localparam int CB_W  = B_W + 2 * SHIFT;

    localparam logic [X_W-1:0]       X_LIM     = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]       Y_LIM     = Y_W'(V_ACTIVE);
    localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(OUT_W * OUT_H - 1);

    typedef struct packed {
        logic [HR_W-1:0] r;
        logic [HG_W-1:0] g;
        logic [HB_W-1:0] b;
    } hsum_t;

    logic [X_W-1:0]       x_r;
    logic [Y_W-1:0]       y_r;
    logic                 href_d_r;
    logic                 vsync_d_r;
    logic                 wrote_r;
    logic                 done_seen_r;
    hsum_t                h_acc_r;
    logic                 wr_en_r;
    logic [FB_ADDR_W-1:0] wr_addr_r;
    logic [PIX_W-1:0]     wr_data_r;
    logic                 frame_done_r;
    logic                 frame_err_r;

    rgb565_t              px_s;
    hsum_t                pxe_s;
    hsum_t                hs_s;
    logic                 href_fall_s;
    logic                 vsync_rise_s;
    logic                 accept_s;
    logic                 blk_end_s;
    logic                 col_load_s;
    logic                 wr_go_s;
    logic                 is_last_s;
    logic [IDX_W-1:0]     col_idx_s;
    logic [FB_ADDR_W-1:0] addr_s;
    logic [CR_W-1:0]      csum_r_s;
    logic [CG_W-1:0]      csum_g_s;
    logic [CB_W-1:0]      csum_b_s;
    rgb565_t              avg_s;
    logic [PIX_W-1:0]     data_s;

    // Pixel qualification, block boundaries, horizontal sum and target address
    always_comb begin
        px_s         = rgb565_unpack(bus.pixel);
        href_fall_s  = href_d_r & ~bus.href;
        vsync_rise_s = bus.vsync & ~vsync_d_r;
        accept_s     = bus.pixel_en & bus.href & ~bus.vsync & (x_r < X_LIM) & (y_r < Y_LIM);
        blk_end_s    = accept_s & (&x_r[SHIFT-1:0]);
        col_load_s   = ~|y_r[SHIFT-1:0];
        wr_go_s      = blk_end_s & (&y_r[SHIFT-1:0]);
        pxe_s.r      = HR_W'(px_s.r);
        pxe_s.g      = HG_W'(px_s.g);
        pxe_s.b      = HB_W'(px_s.b);
        hs_s.r       = h_acc_r.r + pxe_s.r;
        hs_s.g       = h_acc_r.g + pxe_s.g;
        hs_s.b       = h_acc_r.b + pxe_s.b;
        col_idx_s    = IDX_W'(x_r >> SHIFT);
        addr_s       = FB_ADDR_W'(y_r >> SHIFT) * FB_ADDR_W'(OUT_W) + FB_ADDR_W'(x_r >> SHIFT);
        is_last_s    = (addr_s == LAST_ADDR);
    end

    block_col_acc #(
        .DEPTH (OUT_W),
        .IDX_W (IDX_W),
        .HR_W  (HR_W),
        .HG_W  (HG_W),
        .HB_W  (HB_W),
        .CR_W  (CR_W),
        .CG_W  (CG_W),
        .CB_W  (CB_W)
    ) u_col_acc (
        .clk   (i_clk),
        .we    (blk_end_s),
        .load  (col_load_s),
        .idx   (col_idx_s),
        .add_r (hs_s.r),
        .add_g (hs_s.g),
        .add_b (hs_s.b),
        .sum_r (csum_r_s),
        .sum_g (csum_g_s),
        .sum_b (csum_b_s)
    );

    // Block mean: divide the 2^(2*SHIFT) pixel sum by truncation
    always_comb begin
        avg_s.r = R_W'(csum_r_s >> (2 * SHIFT));
        avg_s.g = G_W'(csum_g_s >> (2 * SHIFT));
        avg_s.b = B_W'(csum_b_s >> (2 * SHIFT));
        data_s  = rgb565_pack(avg_s);
    end

    // Position counters, sync edge history and the horizontal accumulator
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            x_r       <= X_W'(0);
            y_r       <= Y_W'(0);
            href_d_r  <= 1'b0;
            vsync_d_r <= 1'b0;
            h_acc_r   <= hsum_t'(0);
        end else begin
            href_d_r  <= bus.href;
            vsync_d_r <= bus.vsync;
            if (bus.vsync) begin
                x_r     <= X_W'(0);
                y_r     <= Y_W'(0);
                h_acc_r <= hsum_t'(0);
            end else if (href_fall_s) begin
                // A partial block at the end of a short line is simply dropped
                x_r     <= X_W'(0);
                h_acc_r <= hsum_t'(0);
                if (x_r != X_W'(0)) begin
                    y_r <= y_r + Y_W'(1);
                end
            end else if (accept_s) begin
                x_r     <= x_r + X_W'(1);
                h_acc_r <= (~|x_r[SHIFT-1:0]) ? pxe_s : hs_s;
            end
        end
    end

    // Registered write port and per-frame status pulses
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_r      <= 1'b0;
            wr_addr_r    <= FB_ADDR_W'(0);
            wr_data_r    <= PIX_W'(0);
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
            wrote_r      <= 1'b0;
            done_seen_r  <= 1'b0;
        end else begin
            wr_en_r      <= wr_go_s;
            frame_done_r <= wr_go_s & is_last_s;
            frame_err_r  <= vsync_rise_s & wrote_r & ~done_seen_r;
            if (wr_go_s) begin
                wr_addr_r <= addr_s;
                wr_data_r <= data_s;
            end
            if (bus.vsync) begin
                wrote_r     <= 1'b0;
                done_seen_r <= 1'b0;
            end else if (wr_go_s) begin
                wrote_r <= 1'b1;
                if (is_last_s) begin
                    done_seen_r <= 1'b1;
                end
            end
        end
    end

    assign bus.wr_en      = wr_en_r;
    assign bus.wr_addr    = wr_addr_r;
    assign bus.wr_data    = wr_data_r;
    assign bus.frame_done = frame_done_r;
    assign bus.frame_err  = frame_err_r;

endmodule

// File: tb/tb_cam_block_decimator.sv
// Scoreboard bench for the block decimator on a reduced 64x32 frame (8x4 blocks).
module tb_cam_block_decimator;

    localparam int H     = 64;
    localparam int V     = 32;
    localparam int OUT_W = 8;
    localparam int LAST  = 31;

    typedef struct {
        logic [12:0] addr;
        logic [15:0] data;
        logic        done;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    int   cyc_cnt;
    int   exp_done;
    int   exp_err;
    int   done_seen;
    int   err_seen;
    exp_t sb[$];
    exp_t e;

    cam_block_decimator_if bus();

    cam_block_decimator #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .SHIFT    (3)
    ) dut (
        .i_clk   (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc_cnt);
        end
    endtask

    // Camera pixel for a given test pattern
    function automatic logic [15:0] pix_fn(input int mode, input int x, input int y);
        logic [9:0] xv;
        xv = 10'(x);
        case (mode)
            0:       return 16'hFFFF;
            1:       return {xv[4:0], 11'd0};
            2:       return ((y / 8) == 2 && (x / 8) == 5) ? 16'h07E0 : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    // Hand-derived block averages: ramp columns give R = 8*(col%4)+3 (x..x+7 mean, truncated)
    function automatic logic [15:0] exp_fn(input int mode, input int bx, input int by);
        logic [4:0] r;
        r = 5'(8 * (bx % 4) + 3);
        case (mode)
            0:       return 16'hFFFF;
            1:       return {r, 11'd0};
            2:       return (by == 2 && bx == 5) ? 16'h07E0 : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic drive(input logic en, input logic [15:0] px, input logic hr, input logic vs);
        bus.pixel_en = en;
        bus.pixel    = px;
        bus.href     = hr;
        bus.vsync    = vs;
        @(posedge clk);
        #1;
    endtask

    // kind 0: full frame, line cut_y truncated after cut_x pixels
    // kind 1: vsync rises just before pixel (cut_y,cut_x); kind 2: reset there instead
    task automatic send_frame(input int mode, input int gap, input int cut_y, input int cut_x,
                              input int kind, input bit extra);
        exp_t t;
        drive(1'b1, 16'hFFFF, 1'b1, 1'b1);
        repeat (3) drive(1'b0, 16'h0000, 1'b0, 1'b1);
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        for (int y = 0; y < V; y++) begin
            int n;
            n = (kind == 0 && y == cut_y) ? cut_x : H;
            for (int x = 0; x < n; x++) begin
                if (kind != 0 && y == cut_y && x == cut_x) begin
                    if (kind == 1) begin
                        repeat (3) drive(1'b0, 16'h0000, 1'b0, 1'b1);
                        exp_err++;
                    end else begin
                        bus.pixel_en = 1'b0;
                        bus.pixel    = 16'h0000;
                        @(negedge clk);
                        #1;
                        reset_n = 1'b0;
                        #1;
                        chk("async_reset_outputs",
                            {bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_done, bus.frame_err}, 32'd0);
                        sb.delete();
                        @(posedge clk);
                        @(posedge clk);
                        #1;
                        reset_n = 1'b1;
                    end
                    return;
                end
                if (x % 8 == 7 && y % 8 == 7) begin
                    t.addr = 13'((y / 8) * OUT_W + x / 8);
                    t.data = exp_fn(mode, x / 8, y / 8);
                    t.done = (int'(t.addr) == LAST);
                    t.cyc  = cyc_cnt + 1;
                    if (t.done) exp_done++;
                    sb.push_back(t);
                end
                drive(1'b1, pix_fn(mode, x, y), 1'b1, 1'b0);
                repeat (gap - 1) drive(1'b0, 16'h0000, 1'b1, 1'b0);
            end
            if (extra) repeat (8) drive(1'b1, 16'hFFFF, 1'b1, 1'b0);
            drive(1'b1, 16'hFFFF, 1'b0, 1'b0);
            drive(1'b0, 16'h0000, 1'b0, 1'b0);
        end
    endtask

    // Monitor: every buffer write is matched against the next expected entry
    always @(negedge clk) begin
        if (bus.wr_en) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual addr=%0d data=%0h required no write", bus.wr_addr, bus.wr_data);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                chk("wr_data", 32'(bus.wr_data), 32'(e.data));
                chk("frame_done_on_write", 32'(bus.frame_done), 32'(e.done));
                chk("wr_latency_cycle", cyc_cnt, e.cyc);
            end
        end
        if (bus.frame_done) begin
            done_seen++;
            chk("frame_done_with_wr_en", 32'(bus.wr_en), 32'd1);
        end
        if (bus.frame_err) err_seen++;
    end

    initial begin
        checks    = 0;
        failures  = 0;
        cyc_cnt   = 0;
        exp_done  = 0;
        exp_err   = 0;
        done_seen = 0;
        err_seen  = 0;
        reset_n   = 1'b0;
        bus.pixel_en = 1'b0;
        bus.pixel    = 16'h0000;
        bus.href     = 1'b0;
        bus.vsync    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_done, bus.frame_err}, 32'd0);
        reset_n = 1'b1;

        send_frame(0, 1, -1, 0, 0, 1'b0);   // constant white
        send_frame(1, 1, -1, 0, 0, 1'b0);   // red ramp, strobe every cycle
        send_frame(1, 3, -1, 0, 0, 1'b0);   // same ramp, strobe every 3rd cycle
        send_frame(2, 1, -1, 0, 0, 1'b1);   // single green block, overlong lines
        send_frame(0, 1, 7, 37, 0, 1'b0);   // short line at the bottom of block row 0
        send_frame(1, 1, -1, 0, 0, 1'b0);   // following frame unaffected
        send_frame(1, 1, 15, 24, 1, 1'b0);  // early vsync after 11 writes
        send_frame(0, 1, -1, 0, 0, 1'b0);   // restart from address 0
        send_frame(0, 1, 15, 16, 2, 1'b0);  // reset mid-line
        send_frame(2, 1, -1, 0, 0, 1'b0);   // clean frame after reset

        repeat (5) drive(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("scoreboard_drained", sb.size(), 32'd0);
        chk("frame_done_count", done_seen, exp_done);
        chk("frame_err_count", err_seen, exp_err);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cam_block_decimator.md
# cam_block_decimator

Box-filter decimator between the camera RGB565 capture stage and the RGB frame buffer. Averages each 8x8 pixel block of the 640x480 camera frame into one RGB565 pixel, producing an 80x60 thumbnail. Each result is written to the buffer with a 13-bit linear address (0..4799), together with a frame-complete pulse. The HDMI side then reads a full, spatially correct image.

## Interface
- H_ACTIVE, 640: active pixels per line.
- V_ACTIVE, 480: active lines per frame.
- SHIFT, 3: log2 of the decimation factor. The block is 2^SHIFT square.
- OUT_W, H_ACTIVE>>SHIFT: output pixels per row (derived, 80).
- i_clk  in  1  pixel clock shared with the capture stage.
- reset_n  in  1  asynchronous active-low reset.
- pixel_en  in  1  one-cycle strobe marking one complete RGB565 pixel. Strobes may occur on every cycle.
- pixel  in  16  RGB565 data: R[15:11], G[10:5], B[4:0]. Valid when pixel_en is high.
- href  in  1  line-active level from the camera.
- vsync  in  1  vertical sync level from the camera. High means between frames.
- wr_en  out  1  one-cycle write strobe to the buffer.
- wr_addr  out  13  write address = row*OUT_W + col.
- wr_data  out  16  averaged RGB565 pixel.
- frame_done  out  1  one-cycle pulse, coincident with the write of address 4799.
- frame_err  out  1  one-cycle pulse when vsync rises before a full frame has been written.

## Operation
- Counters:
  - x (10 bits) counts accepted pixels in the current line.
  - y (9 bits) counts lines in the frame.
  - A pixel is accepted only if pixel_en=1, href=1, vsync=0, x<H_ACTIVE and y<V_ACTIVE. Other strobes are ignored.
- Horizontal sum: per-channel accumulator h_acc, widths R 8b, G 9b, B 8b.
  - Cleared when x[2:0]=0 (the new pixel is loaded), otherwise adds the new pixel.
  - The block-column sum hs = h_acc + pixel is formed at x[2:0]=7.
- Column accumulators: col_acc[0..79], per channel R 11b, G 12b, B 11b.
  - At x[2:0]=7, entry x>>3 is loaded with hs when y[2:0]=0, else col_acc + hs.
- Output: at x[2:0]=7 and y[2:0]=7:
  - wr_data = {(col_acc+hs)>>6} per channel, truncated with no rounding.
  - wr_addr = (y>>3)*80 + (x>>3).
  - wr_en=1.
- Line end: the falling edge of href (registered href=1, current href=0) does the following:
  - clears x and h_acc;
  - increments y if x>0;
  - discards any partial horizontal block.
- Frame start: vsync=1 holds x=0, y=0, h_acc=0. Column accumulators need no clear, because y[2:0]=0 reloads them.
- frame_done: pulses with the write of wr_addr=4799.
- frame_err: the rising edge of vsync pulses frame_err if at least one write occurred in this frame and frame_done has not.
- Simultaneous events:
  - vsync rising in the same cycle as an accepted pixel: vsync wins and the pixel is dropped.
  - href falling in the same cycle as pixel_en: the pixel is ignored (href=0).

## Timing
- Latency: wr_en/wr_addr/wr_data are registered and asserted on the cycle after the accepting pixel_en edge.
- Throughput: one write per 8 accepted pixels, on 1 of every 8 lines.
- All outputs reset to 0: wr_en, wr_addr, wr_data, frame_done, frame_err.
- Internal counters, h_acc and edge-detect registers reset to 0. The href/vsync edge-detect registers reset to 0.
- Reset mid-frame: all state clears asynchronously. Output resumes correctly from the next vsync; writes before that vsync are not required to be meaningful.
- The buffer samples wr_* on i_clk. There is no backpressure; the buffer always accepts.

## Structure
- The shared package cam_pkg holds:
  - RGB565 field positions and channel widths;
  - H_ACTIVE/V_ACTIVE defaults;
  - FB_ADDR_W=13;
  - the function rgb565_unpack.
- Sub-module block_col_acc: the 80-entry accumulator register array. It has an asynchronous read and a synchronous write with load/add select, so a read-modify-write completes in one cycle.
- Top: counters, href/vsync edge detection, h_acc, output register, status pulses.

## Test plan
- Constant frame, all pixels 16'hFFFF, 640x480 -> 4800 writes, addresses 0..4799 in order. Every wr_data=16'hFFFF. One frame_done pulse on the write of address 4799.
- Frame with pixel = {x[4:0],6'd0,5'd0} -> each block R = trunc(mean of 8 consecutive x values)>>0. For example, block col 0 has R=3 (0..7 average 3.5, truncated); G=0, B=0.
- Block (row 2, col 5) set to 16'h07E0, all else 0 -> exactly one write at addr 165 with data 16'h07E0. All other writes are 0.
- pixel_en strobing every cycle and then every 3rd cycle within a line -> identical wr_data/addr sequences; wr_en asserted exactly 1 cycle after the 8th accepted pixel.
- href drops after 300 pixels on line 7 -> blocks 0..36 written for block row 0. Block 37 is not written. y advances; the next frame is unaffected.
- vsync rises after 1000 writes -> frame_err pulses once with no frame_done. A following full frame restarts at addr 0. Asserting reset_n=0 mid-line clears all outputs immediately.
